// File: rtl/priority_event_scheduler.sv
// Sticky event capture with one-at-a-time valid/ready service.
// Fixed (MSB first) or round-robin selection over pending | incoming requests.
module priority_event_scheduler #(
   parameter int N  = 8,
   parameter int W  = 3,
   parameter int RR = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic         clear_all,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pending,
   output logic         overflow
);

   logic [N-1:0] pending_q, pending_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_idx_q, out_idx_d;
   logic         overflow_q, overflow_d;
   logic [W-1:0] rr_ptr_q, rr_ptr_d;

   logic [N-1:0] eff;
   logic [N-1:0] sel_oh;
   logic [W-1:0] sel;
   logic         slot_free;
   logic         found;
   int           start;
   int           idx;

   always_comb begin
      eff       = pending_q | req_in;
      slot_free = !out_valid_q || out_ready;
      sel       = '0;
      found     = 1'b0;
      start     = 0;
      idx       = 0;
      if (RR != 0) begin
         // descending search that begins just below the last served line
         start = (int'(rr_ptr_q) + N - 1) % N;
         for (int i = 0; i < N; i++) begin
            idx = (start + N - i) % N;
            if (!found && eff[idx]) begin
               sel   = W'(idx);
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (eff[i]) sel = W'(i);
         end
      end
      sel_oh      = '0;
      sel_oh[sel] = 1'b1;
   end

   always_comb begin
      pending_d   = pending_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      rr_ptr_d    = rr_ptr_q;
      // the offered bit is not in pending_q, so a repeat on it is not overflow
      overflow_d  = overflow_q | (|(req_in & pending_q));
      if (slot_free) begin
         if (|eff) begin
            out_idx_d   = sel;
            out_valid_d = 1'b1;
            pending_d   = eff & ~sel_oh;
            rr_ptr_d    = sel;
         end else begin
            out_valid_d = 1'b0;
            pending_d   = '0;
         end
      end else begin
         pending_d = eff;
      end
      if (clear_all) begin
         pending_d   = '0;
         out_valid_d = 1'b0;
         out_idx_d   = '0;
         overflow_d  = 1'b0;
         rr_ptr_d    = rr_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         overflow_q  <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         overflow_q  <= overflow_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_priority_event_scheduler.sv
// Drives a fixed-priority and a round-robin scheduler with the same vectors.
// Accepted indices are checked against per-instance expected queues.
module tb_priority_event_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in;
   logic       clear_all;
   logic       out_ready;

   logic       f_valid, r_valid;
   logic [2:0] f_idx, r_idx;
   logic [7:0] f_pend, r_pend;
   logic       f_ovf, r_ovf;

   int checks = 0;
   int errors = 0;

   int q_f[$];
   int q_r[$];

   always #5 clk = ~clk;

   priority_event_scheduler #(.N(8), .W(3), .RR(0)) dut_f (
      .clk(clk), .rst(rst), .req_in(req_in), .clear_all(clear_all),
      .out_ready(out_ready), .out_valid(f_valid), .out_idx(f_idx),
      .pending(f_pend), .overflow(f_ovf)
   );

   priority_event_scheduler #(.N(8), .W(3), .RR(1)) dut_r (
      .clk(clk), .rst(rst), .req_in(req_in), .clear_all(clear_all),
      .out_ready(out_ready), .out_valid(r_valid), .out_idx(r_idx),
      .pending(r_pend), .overflow(r_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_both(input logic vf, input logic [7:0] pf, input logic of,
                             input logic vr, input logic [7:0] pr, input logic orr,
                             input string tag);
      check({tag, " fix valid"}, 32'(f_valid), 32'(vf));
      check({tag, " fix pending"}, 32'(f_pend), 32'(pf));
      check({tag, " fix overflow"}, 32'(f_ovf), 32'(of));
      check({tag, " rr valid"}, 32'(r_valid), 32'(vr));
      check({tag, " rr pending"}, 32'(r_pend), 32'(pr));
      check({tag, " rr overflow"}, 32'(r_ovf), 32'(orr));
   endtask

   // acceptance monitor: a handshake visible at negedge completes at the next posedge
   always @(negedge clk) begin
      if (!rst && !clear_all && out_ready) begin
         if (f_valid) begin
            checks++;
            if (q_f.size() == 0) begin
               errors++;
               $display("FAIL fix accept: got idx %0d, expected no acceptance", f_idx);
            end else begin
               int e;
               e = q_f.pop_front();
               if (int'(f_idx) != e) begin
                  errors++;
                  $display("FAIL fix accept: got idx %0d, expected %0d", f_idx, e);
               end
            end
         end
         if (r_valid) begin
            checks++;
            if (q_r.size() == 0) begin
               errors++;
               $display("FAIL rr accept: got idx %0d, expected no acceptance", r_idx);
            end else begin
               int e;
               e = q_r.pop_front();
               if (int'(r_idx) != e) begin
                  errors++;
                  $display("FAIL rr accept: got idx %0d, expected %0d", r_idx, e);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_in = 8'hFF; clear_all = 1'b0; out_ready = 1'b0;

      // 1: reset discards requests
      tick(); tick();
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t1 in reset");
      rst = 1'b0; req_in = 8'h00;
      tick();
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t1 after reset");

      // 2: single pulse, drained in priority order
      out_ready = 1'b1;
      q_f.push_back(7); q_f.push_back(5); q_f.push_back(2); q_f.push_back(0);
      q_r.push_back(7); q_r.push_back(5); q_r.push_back(2); q_r.push_back(0);
      req_in = 8'b1010_0101;
      tick();
      req_in = 8'h00;
      check("t2 fix first idx", 32'(f_idx), 32'd7);
      check("t2 fix first pending", 32'(f_pend), 32'h25);
      tick(); tick(); tick(); tick();
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t2 drained");

      // 3: standing offer is not preempted by a higher line
      out_ready = 1'b0;
      req_in = 8'h08; tick();
      req_in = 8'h00; tick();
      req_in = 8'h80; tick();
      req_in = 8'h00; tick();
      check("t3 fix held idx", 32'(f_idx), 32'd3);
      check("t3 rr held idx", 32'(r_idx), 32'd3);
      check_both(1, 8'h80, 0, 1, 8'h80, 0, "t3 stalled");
      q_f.push_back(3); q_f.push_back(7);
      q_r.push_back(3); q_r.push_back(7);
      out_ready = 1'b1;
      tick();
      check("t3 fix next idx", 32'(f_idx), 32'd7);
      check("t3 rr next idx", 32'(r_idx), 32'd7);
      tick();
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t3 drained");

      // 4: held requests, round-robin alternates, fixed starves line 0
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         q_f.push_back(7);
         q_r.push_back((i % 2 == 0) ? 7 : 0);
      end
      q_f.push_back(0);
      q_r.push_back(7);
      req_in = 8'h81;
      tick();
      check("t4 fix ovf cycle1", 32'(f_ovf), 32'd0);
      check("t4 rr ovf cycle1", 32'(r_ovf), 32'd0);
      tick();
      check("t4 fix pending cycle2", 32'(f_pend), 32'h01);
      check("t4 fix ovf cycle2", 32'(f_ovf), 32'd1);
      check("t4 rr pending cycle2", 32'(r_pend), 32'h80);
      check("t4 rr ovf cycle2", 32'(r_ovf), 32'd1);
      tick(); tick(); tick(); tick();
      req_in = 8'h00;
      check("t4 fix idx cycle6", 32'(f_idx), 32'd7);
      check("t4 rr idx cycle6", 32'(r_idx), 32'd0);
      tick(); tick();
      check_both(0, 8'h00, 1, 0, 8'h00, 1, "t4 drained");
      clear_all = 1'b1; tick(); clear_all = 1'b0;
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t4 cleared");

      // 5: duplicate on a pending line sets overflow; flush clears everything
      out_ready = 1'b0;
      req_in = 8'h20; tick();
      req_in = 8'h04; tick();
      req_in = 8'h00; tick();
      check("t5 fix ovf one pulse", 32'(f_ovf), 32'd0);
      req_in = 8'h04; tick();
      req_in = 8'h00;
      check("t5 fix idx", 32'(f_idx), 32'd5);
      check("t5 rr idx", 32'(r_idx), 32'd5);
      check_both(1, 8'h04, 1, 1, 8'h04, 1, "t5 dup");
      clear_all = 1'b1; tick(); clear_all = 1'b0;
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t5 cleared");

      // 6: flush drops the offer and a simultaneous request, keeps rr pointer
      req_in = 8'h02; tick();
      req_in = 8'h00;
      check("t6 rr offer", 32'(r_idx), 32'd1);
      clear_all = 1'b1; req_in = 8'h10; tick();
      clear_all = 1'b0; req_in = 8'h00;
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t6 cleared");
      out_ready = 1'b1;
      q_f.push_back(7); q_f.push_back(2); q_f.push_back(0);
      q_r.push_back(0); q_r.push_back(7); q_r.push_back(2);
      req_in = 8'b1000_0101; tick();
      req_in = 8'h00;
      check("t6 rr first after flush", 32'(r_idx), 32'd0);
      tick(); tick(); tick();
      check_both(0, 8'h00, 0, 0, 8'h00, 0, "t6 drained");

      check("fix queue empty", 32'(q_f.size()), 32'd0);
      check("rr queue empty", 32'(q_r.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
